aes_round_sequencer: RTL and testbench
======================================

# aes_round_sequencer

Parametrised iterative round controller for the AES datapath. It sequences the shared round logic for both encryption and decryption at 128-, 192- or 256-bit key lengths. Once per accepted block it drives the round-type select, round/key-schedule index and state-register write enable, then holds the finished result under a valid/ready output handshake. It sits between the block-level input/output interfaces and the combinational round stages (initial add-round-key, middle round, final round).

## Interface
Parameters:
- IDX_W, 8, width of round_idx; must be ≥ 4.
- ALLOW_192, 1, when 0 key_len=01 is treated as illegal.
- ALLOW_256, 1, when 0 key_len=10 is treated as illegal.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  a block and key are presented.
- in_ready  out  1  sequencer can accept a block; high only in IDLE.
- decrypt  in  1  mode, sampled on acceptance: 0 = encrypt, 1 = decrypt.
- key_len  in  2  key length, sampled on acceptance: 00 = 128 (Nr=10), 01 = 192 (Nr=12), 10 = 256 (Nr=14), 11 = illegal.
- flush  in  1  synchronous abort.
- round_sel  out  2  round type: 00 none, 01 initial ARK, 10 middle round, 11 final round.
- round_idx  out  IDX_W  key-schedule round number for the current cycle.
- state_we  out  1  state/key registers capture the round output this cycle.
- out_valid  out  1  result is held in the state register.
- out_ready  in  1  consumer takes the result.
- busy  out  1  high in INIT, ROUND and FINAL.
- err  out  1  one-cycle pulse on an illegal key_len acceptance.

## Operation
- **States:** IDLE, INIT, ROUND, FINAL, DONE.
- **IDLE**
  - in_ready=1; all other outputs are 0.
  - in_valid with a legal key_len: latch decrypt and Nr, go to INIT.
  - in_valid with an illegal key_len (11, or 01/10 disabled by parameter): the request is consumed, err pulses next cycle, state stays IDLE.
- **INIT** (1 cycle)
  - round_sel=01, state_we=1.
  - round_idx = 0 (encrypt) or Nr (decrypt).
  - Go to ROUND.
- **ROUND** (Nr−1 cycles)
  - round_sel=10, state_we=1.
  - Encrypt: round_idx counts 1, 2, … Nr−1.
  - Decrypt: round_idx counts Nr−1, Nr−2, … 1.
  - After the cycle with round_idx=Nr−1 (encrypt) or round_idx=1 (decrypt), go to FINAL.
- **FINAL** (1 cycle)
  - round_sel=11, state_we=1.
  - round_idx = Nr (encrypt) or 0 (decrypt).
  - Go to DONE.
- **DONE**
  - out_valid=1, round_sel=00, state_we=0; round_idx holds its FINAL value.
  - out_valid & out_ready: return to IDLE next cycle.
  - With out_ready low, out_valid stays high indefinitely and no state_we is issued.
- **Round counter:** internal, 4 bits, never wraps; Nr is fixed for the whole block. round_idx is zero-extended to IDX_W.
- **flush**
  - In any state other than IDLE: go to IDLE next cycle with no out_valid and no further state_we.
  - flush in IDLE has no effect and does not block acceptance.
  - flush and out_ready together in DONE: go to IDLE, result counts as consumed.
- **Reset** (any time, including mid-operation): state=IDLE, in_ready=1, every other output 0, latched mode/Nr cleared. The block in flight is abandoned.

## Timing
- All outputs are registered or decoded from registered state only; there is no combinational path from in_valid/out_ready/flush to any output.
- **Acceptance** occurs at the rising edge where in_valid & in_ready.
- **Latency** (acceptance edge E to first out_valid cycle):
  - INIT occupies cycle E+1; ROUND cycles E+2 … E+Nr; FINAL cycle E+Nr+1.
  - out_valid is high from cycle E+Nr+2: 12 / 14 / 16 cycles for 128 / 192 / 256.
- **state_we:** exactly Nr+1 pulses per completed block.
- **Throughput:** minimum Nr+3 cycles between acceptances. There is one IDLE cycle after the DONE handshake; no overlap of blocks.
- **err** is high exactly in cycle E+1 of an illegal acceptance; in_ready stays 1 throughout.

## Test plan
- **Encrypt, key_len=00, out_ready=1:** round_idx sequence 0, 1 … 9, 10 with round_sel 01, 10×9, 11. Ten state_we pulses… correction: state_we high for 11 cycles. out_valid is high 12 cycles after acceptance for one cycle, then in_ready returns.
- **Decrypt, key_len=10:** round_idx 14, 13 … 1, 0. Exactly 15 state_we pulses. out_valid at E+16.
- **key_len=11, and separately ALLOW_256=0 with key_len=10:** err is one-cycle high at E+1, state_we and busy are never asserted, in_ready stays 1.
- **Backpressure:** out_ready held low for 5 cycles in DONE. out_valid stays high and state_we stays 0 for all 5 cycles; IDLE one cycle after out_ready rises.
- **Abort:**
  - reset asserted during ROUND at round_idx=4, asynchronously: outputs clear immediately, in_ready=1, no out_valid.
  - flush in ROUND: IDLE next cycle, no out_valid.
- **Back-to-back:** encrypt-128 then decrypt-192 with in_valid held high. The second block is accepted the cycle after the first handshake, its sequence is 12, 11 … 0, and decrypt is latched independently per block.

Source files
------------

// File: rtl/aes_round_sequencer.sv
// Iterative AES round controller: sequences initial/middle/final rounds for
// encrypt and decrypt at 128/192/256-bit keys, then holds the result under valid/ready.
module aes_round_sequencer #(
    parameter int IDX_W     = 8,
    parameter bit ALLOW_192 = 1'b1,
    parameter bit ALLOW_256 = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             decrypt,
    input  logic [1:0]       key_len,
    input  logic             flush,
    output logic [1:0]       round_sel,
    output logic [IDX_W-1:0] round_idx,
    output logic             state_we,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             err
);

    typedef enum logic [2:0] {
        S_IDLE, S_INIT, S_ROUND, S_FINAL, S_DONE
    } state_t;

    localparam logic [1:0] SEL_NONE  = 2'b00;
    localparam logic [1:0] SEL_INIT  = 2'b01;
    localparam logic [1:0] SEL_MID   = 2'b10;
    localparam logic [1:0] SEL_FINAL = 2'b11;

    state_t     state;
    logic       dec_q;
    logic [3:0] nr_q;
    logic [3:0] cnt;
    logic       to_idle;
    logic       last_mid;

    function automatic logic [3:0] nr_of(input logic [1:0] kl);
        case (kl)
            2'b00:   nr_of = 4'd10;
            2'b01:   nr_of = 4'd12;
            default: nr_of = 4'd14;
        endcase
    endfunction

    function automatic logic key_legal(input logic [1:0] kl);
        case (kl)
            2'b00:   key_legal = 1'b1;
            2'b01:   key_legal = ALLOW_192;
            2'b10:   key_legal = ALLOW_256;
            default: key_legal = 1'b0;
        endcase
    endfunction

    // Leaving for IDLE either aborts the block (flush) or completes the handshake.
    assign to_idle  = (state != S_IDLE && flush) || (state == S_DONE && out_ready);
    assign last_mid = dec_q ? (cnt == 4'd1) : (cnt == nr_q - 4'd1);
    assign round_idx = IDX_W'(cnt);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            dec_q     <= 1'b0;
            nr_q      <= 4'd0;
            cnt       <= 4'd0;
            round_sel <= SEL_NONE;
            state_we  <= 1'b0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            err       <= 1'b0;
        end else begin
            err <= 1'b0;
            if (to_idle) begin
                state     <= S_IDLE;
                cnt       <= 4'd0;
                round_sel <= SEL_NONE;
                state_we  <= 1'b0;
                out_valid <= 1'b0;
                busy      <= 1'b0;
                in_ready  <= 1'b1;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (in_valid) begin
                            if (key_legal(key_len)) begin
                                state     <= S_INIT;
                                dec_q     <= decrypt;
                                nr_q      <= nr_of(key_len);
                                cnt       <= decrypt ? nr_of(key_len) : 4'd0;
                                round_sel <= SEL_INIT;
                                state_we  <= 1'b1;
                                busy      <= 1'b1;
                                in_ready  <= 1'b0;
                            end else begin
                                err <= 1'b1;
                            end
                        end
                    end
                    S_INIT: begin
                        state     <= S_ROUND;
                        cnt       <= dec_q ? nr_q - 4'd1 : 4'd1;
                        round_sel <= SEL_MID;
                    end
                    S_ROUND: begin
                        if (last_mid) begin
                            state     <= S_FINAL;
                            cnt       <= dec_q ? 4'd0 : nr_q;
                            round_sel <= SEL_FINAL;
                        end else begin
                            cnt <= dec_q ? cnt - 4'd1 : cnt + 4'd1;
                        end
                    end
                    S_FINAL: begin
                        // round_idx keeps its final-round value while the result is held
                        state     <= S_DONE;
                        round_sel <= SEL_NONE;
                        state_we  <= 1'b0;
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                    end
                    S_DONE: begin
                        state <= S_DONE;
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Directed bench for aes_round_sequencer: inputs change and outputs are sampled on
// the falling edge, so each sample shows the state registered at the previous rising edge.
module tb_aes_round_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid, iv2;
    logic       decrypt;
    logic [1:0] key_len;
    logic       flush;
    logic       out_ready;

    logic       in_ready, state_we, out_valid, busy, err;
    logic [1:0] round_sel;
    logic [7:0] round_idx;

    logic       in_ready2, state_we2, out_valid2, busy2, err2;
    logic [1:0] round_sel2;
    logic [7:0] round_idx2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    aes_round_sequencer #(.IDX_W(8), .ALLOW_192(1'b1), .ALLOW_256(1'b1)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .decrypt(decrypt), .key_len(key_len), .flush(flush),
        .round_sel(round_sel), .round_idx(round_idx), .state_we(state_we),
        .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .err(err)
    );

    aes_round_sequencer #(.IDX_W(8), .ALLOW_192(1'b1), .ALLOW_256(1'b0)) dut_no256 (
        .clk(clk), .reset(reset), .in_valid(iv2), .in_ready(in_ready2),
        .decrypt(decrypt), .key_len(key_len), .flush(flush),
        .round_sel(round_sel2), .round_idx(round_idx2), .state_we(state_we2),
        .out_valid(out_valid2), .out_ready(out_ready), .busy(busy2), .err(err2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Present one block at a falling edge; returns at the sample of cycle E+1.
    task automatic start(input logic dec, input logic [1:0] kl, input logic hold_valid);
        in_valid = 1'b1;
        decrypt  = dec;
        key_len  = kl;
        @(negedge clk);
        in_valid = hold_valid;
    endtask

    // Checks INIT/ROUND/FINAL cycles; returns at the sample of cycle E+Nr+2.
    task automatic run_seq(input string name, input logic dec, input int nr);
        int we_cnt = 0;
        int sel_bad = 0;
        int idx_bad = 0;
        int exp_sel, exp_idx;
        for (int k = 0; k <= nr; k++) begin
            exp_sel = (k == 0) ? 1 : ((k == nr) ? 3 : 2);
            exp_idx = dec ? nr - k : k;
            if (round_sel !== 2'(exp_sel)) sel_bad++;
            if (round_idx !== 8'(exp_idx)) begin
                idx_bad++;
                $display("FAIL %s idx[%0d]: got=%0d expected=%0d", name, k, round_idx, exp_idx);
            end
            if (state_we === 1'b1) we_cnt++;
            if (k == 0) chk({name, " busy"}, busy, 1);
            if (out_valid !== 1'b0) sel_bad++;
            @(negedge clk);
        end
        chk({name, " sel/out_valid seq"}, sel_bad, 0);
        total++;
        if (idx_bad != 0) bad++;
        chk({name, " we pulses"}, we_cnt, nr + 1);
        chk({name, " out_valid"}, out_valid, 1);
        chk({name, " done we"}, state_we, 0);
        chk({name, " done sel"}, round_sel, 0);
        chk({name, " done idx"}, round_idx, dec ? 0 : nr);
        chk({name, " done busy"}, busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int seen;
        reset = 1'b1; in_valid = 1'b0; iv2 = 1'b0; decrypt = 1'b0;
        key_len = 2'b00; flush = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        chk("rst in_ready", in_ready, 1);
        chk("rst outputs", {round_sel, round_idx, state_we, out_valid, busy, err}, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Encrypt 128: one out_valid cycle then IDLE
        start(1'b0, 2'b00, 1'b0);
        run_seq("enc128", 1'b0, 10);
        @(negedge clk);
        chk("enc128 idle in_ready", in_ready, 1);
        chk("enc128 idle out_valid", out_valid, 0);
        chk("enc128 idle idx", round_idx, 0);

        // Decrypt 256
        start(1'b1, 2'b10, 1'b0);
        run_seq("dec256", 1'b1, 14);
        @(negedge clk);
        chk("dec256 idle in_ready", in_ready, 1);

        // Illegal key_len 11
        start(1'b0, 2'b11, 1'b0);
        chk("kl11 err", err, 1);
        chk("kl11 in_ready", in_ready, 1);
        chk("kl11 busy/we", {busy, state_we}, 0);
        @(negedge clk);
        chk("kl11 err pulse", err, 0);
        chk("kl11 busy/we after", {busy, state_we}, 0);

        // 256 disabled on second instance
        iv2 = 1'b1; key_len = 2'b10;
        @(negedge clk);
        iv2 = 1'b0;
        chk("no256 err", err2, 1);
        chk("no256 in_ready", in_ready2, 1);
        chk("no256 busy/we", {busy2, state_we2}, 0);
        @(negedge clk);
        chk("no256 err pulse", err2, 0);
        chk("no256 busy/we after", {busy2, state_we2}, 0);

        // Backpressure: 5 cycles held in DONE
        out_ready = 1'b0;
        start(1'b0, 2'b01, 1'b0);
        run_seq("enc192 bp", 1'b0, 12);
        for (int i = 1; i < 5; i++) begin
            @(negedge clk);
            chk("bp out_valid", out_valid, 1);
            chk("bp we", state_we, 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp idle in_ready", in_ready, 1);
        chk("bp idle out_valid", out_valid, 0);

        // Async reset mid-ROUND at round_idx 4
        start(1'b0, 2'b00, 1'b0);
        repeat (4) @(negedge clk);
        chk("pre-reset idx", round_idx, 4);
        #2 reset = 1'b1;
        #1;
        chk("async rst in_ready", in_ready, 1);
        chk("async rst outputs", {round_sel, round_idx, state_we, out_valid, busy}, 0);
        @(negedge clk);
        reset = 1'b0;
        seen = 0;
        repeat (15) begin
            @(negedge clk);
            if (out_valid || state_we) seen++;
        end
        chk("post-reset quiet", seen, 0);

        // Flush during ROUND
        start(1'b1, 2'b00, 1'b0);
        repeat (3) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush in_ready", in_ready, 1);
        chk("flush outputs", {round_sel, state_we, busy}, 0);
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid || state_we) seen++;
        end
        chk("post-flush quiet", seen, 0);

        // Flush in IDLE does not block acceptance
        flush = 1'b1;
        start(1'b0, 2'b00, 1'b0);
        flush = 1'b0;
        chk("idle flush accept sel", round_sel, 1);
        chk("idle flush accept we", state_we, 1);
        repeat (11) @(negedge clk);
        chk("idle flush done", out_valid, 1);
        @(negedge clk);

        // Back-to-back: enc128 then dec192 with in_valid held high
        start(1'b0, 2'b00, 1'b1);
        decrypt = 1'b1; key_len = 2'b01;
        run_seq("b2b enc128", 1'b0, 10);
        chk("b2b done in_ready", in_ready, 0);
        @(negedge clk);
        chk("b2b idle in_ready", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        run_seq("b2b dec192", 1'b1, 12);
        @(negedge clk);
        chk("b2b end in_ready", in_ready, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
